// File: rtl/input_conditioner.sv
// input_conditioner
// Conditions the raw, asynchronous mode switch for the ROM-based state
// machine. The switch is synchronised with two flops, debounced by a
// four-state qualification FSM, and presented as a clean level `a_out`.
// The block also drives one-cycle edge pulses, a busy flag and a
// saturating press counter.
//
// Optional feature macro: A_TOGGLE_EN
//   undefined : a_out follows the debounced level (level mode)
//   defined   : a_out is a toggle register that flips on every accepted rise
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             btn_raw,
    input  logic             clr_cnt,
    output logic             a_out,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [7:0]       DEB_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    state_t           state_d;
    logic [7:0]       q_q;
    logic [7:0]       q_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [CNT_W-1:0] press_cnt_q;
    logic [CNT_W-1:0] press_cnt_d;

    // Two-flop synchroniser bringing the asynchronous switch into clk.
    always_ff @(posedge clk) begin
        if (!res) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // FSM state register together with the qualification counter,
    // debounced level and the registered edge pulses.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= IDLE_LO;
            q_q      <= 8'd0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Next-state logic: a candidate level must be seen on DEBOUNCE_CYCLES+1
    // consecutive synchronised samples before it is accepted.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (state_q)
            IDLE_LO: begin
                if (s2_q) begin
                    state_d = WAIT_HI;
                    q_d     = 8'd1;
                end
            end
            WAIT_HI: begin
                if (!s2_q) begin
                    state_d = IDLE_LO;
                    q_d     = 8'd0;
                end else if (q_q == DEB_LIMIT) begin
                    state_d  = IDLE_HI;
                    q_d      = 8'd0;
                    stable_d = 1'b1;
                    rise_d   = 1'b1;
                end else begin
                    q_d = q_q + 8'd1;
                end
            end
            IDLE_HI: begin
                if (!s2_q) begin
                    state_d = WAIT_LO;
                    q_d     = 8'd1;
                end
            end
            WAIT_LO: begin
                if (s2_q) begin
                    state_d = IDLE_HI;
                    q_d     = 8'd0;
                end else if (q_q == DEB_LIMIT) begin
                    state_d  = IDLE_LO;
                    q_d      = 8'd0;
                    stable_d = 1'b0;
                    fall_d   = 1'b1;
                end else begin
                    q_d = q_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                q_d     = 8'd0;
            end
        endcase
    end

    // Output decode: busy while a candidate change is being qualified.
    always_comb begin
        busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    end

    // Press counter next value: clear has priority over a same-edge rise,
    // and the count sticks at its maximum.
    always_comb begin
        press_cnt_d = press_cnt_q;
        if (clr_cnt) begin
            press_cnt_d = '0;
        end else if (rise_d && (press_cnt_q != CNT_MAX)) begin
            press_cnt_d = press_cnt_q + 1'b1;
        end
    end

    // Press counter register, counting on the accepting edge of each rise.
    always_ff @(posedge clk) begin
        if (!res) begin
            press_cnt_q <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

`ifdef A_TOGGLE_EN
    logic toggle_q;

    // Toggle register: each accepted rise flips the mode seen by the FSM.
    always_ff @(posedge clk) begin
        if (!res) begin
            toggle_q <= 1'b0;
        end else if (rise_d) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign a_out = toggle_q;
`else
    assign a_out = stable_q;
`endif

    assign rise      = rise_q;
    assign fall      = fall_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner. Two instances share stimulus:
// one with the default 8-bit counter and one with a 2-bit counter so that
// saturation is reachable. Expected outputs come from a run-length model of
// the debouncer and are pushed into a queue; a monitor pops and compares.
module tb_input_conditioner;

    localparam int DEB = 4;

    typedef struct packed {
        logic       a;
        logic       r;
        logic       f;
        logic       b;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    logic       clk = 1'b0;
    logic       res;
    logic       btnRaw;
    logic       clrCnt;
    logic       aOut8, rise8, fall8, busy8;
    logic [7:0] cnt8;
    logic       aOut2, rise2, fall2, busy2;
    logic [1:0] cnt2;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: synchroniser pipeline and a run-length counter
    // of samples that disagree with the accepted level.
    int   mS1, mS2, mRun, mStable, mTog, mCnt8, mCnt2;

    input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut8 (
        .clk(clk), .res(res), .btn_raw(btnRaw), .clr_cnt(clrCnt),
        .a_out(aOut8), .rise(rise8), .fall(fall8), .busy(busy8), .press_cnt(cnt8)
    );

    input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(2)) dut2 (
        .clk(clk), .res(res), .btn_raw(btnRaw), .clr_cnt(clrCnt),
        .a_out(aOut2), .rise(rise2), .fall(fall2), .busy(busy2), .press_cnt(cnt2)
    );

    always #5 clk = ~clk;

    // Compare one field and record the result.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the coming edge and
    // queue the outputs that edge must produce.
    task automatic applyStimulus(input logic btn, input logic rstN, input logic clr);
        exp_t e;
        int   samp, r, f;
        @(negedge clk);
        btnRaw = btn;
        res    = rstN;
        clrCnt = clr;
        r = 0;
        f = 0;
        if (!rstN) begin
            mS1 = 0; mS2 = 0; mRun = 0; mStable = 0; mTog = 0; mCnt8 = 0; mCnt2 = 0;
        end else begin
            samp = mS2;
            if (samp != mStable) begin
                mRun++;
                if (mRun == DEB + 1) begin
                    mStable = samp;
                    mRun    = 0;
                    r       = samp;
                    f       = 1 - samp;
                end
            end else begin
                mRun = 0;
            end
            if (clr) begin
                mCnt8 = 0;
                mCnt2 = 0;
            end else if (r == 1) begin
                if (mCnt8 < 255) mCnt8++;
                if (mCnt2 < 3)   mCnt2++;
            end
            if (r == 1) mTog = 1 - mTog;
            mS2 = mS1;
            mS1 = int'(btn);
        end
`ifdef A_TOGGLE_EN
        e.a = mTog[0];
`else
        e.a = mStable[0];
`endif
        e.r  = r[0];
        e.f  = f[0];
        e.b  = (mRun != 0);
        e.c8 = 8'(mCnt8);
        e.c2 = 2'(mCnt2);
        expQ.push_back(e);
    endtask

    // Monitor: after every rising edge the DUTs present a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("a_out", {7'd0, aOut8}, {7'd0, e.a});
                checkOutput("rise",  {7'd0, rise8}, {7'd0, e.r});
                checkOutput("fall",  {7'd0, fall8}, {7'd0, e.f});
                checkOutput("busy",  {7'd0, busy8}, {7'd0, e.b});
                checkOutput("press_cnt8", cnt8, e.c8);
                checkOutput("a_out_w2", {7'd0, aOut2}, {7'd0, e.a});
                checkOutput("rise_w2",  {7'd0, rise2}, {7'd0, e.r});
                checkOutput("fall_w2",  {7'd0, fall2}, {7'd0, e.f});
                checkOutput("busy_w2",  {7'd0, busy2}, {7'd0, e.b});
                checkOutput("press_cnt2", {6'd0, cnt2}, {6'd0, e.c2});
            end
        end
    end

    // Directed scenarios followed by randomized switch activity.
    initial begin
        int runLen;
        logic lvl;
        btnRaw = 1'b0;
        res    = 1'b0;
        clrCnt = 1'b0;
        mS1 = 0; mS2 = 0; mRun = 0; mStable = 0; mTog = 0; mCnt8 = 0; mCnt2 = 0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Clean press, then release.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Bounce pattern that must be rejected.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Five presses; clear lands on the accepting edge of the fifth.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, (p == 4) && (i == DEB + 2));
            for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        end

        // Reset while qualifying a rise, button held high through reset.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Randomized switch activity with bursts of bounce.
        lvl = 1'b0;
        for (int k = 0; k < 400; k++) begin
            lvl    = ~lvl;
            runLen = $urandom_range(1, 10);
            for (int i = 0; i < runLen; i++) begin
                applyStimulus(lvl, ($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0));
            end
        end

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        checkOutput("queue_drained", 8'(expQ.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Upstream conditioning stage for the ROM-based state machine's mode input `A`. Takes a raw, asynchronous, possibly bouncing switch signal and synchronises it into `clk`. It then debounces it with a counter-based FSM and produces a clean level `a_out` that drives `A` directly. It also provides single-cycle edge pulses and a saturating press counter for the bench and for status logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change; legal range 1..255.
- `CNT_W`, default 8: width of `press_cnt`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `res` in 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `btn_raw` in 1: raw asynchronous switch input.
- `clr_cnt` in 1: synchronous clear of `press_cnt`.
- `a_out` in/out: out 1, conditioned level to the state machine's `A` input.
- `rise` out 1: one-cycle pulse when the debounced level goes 0→1.
- `fall` out 1: one-cycle pulse when the debounced level goes 1→0.
- `busy` out 1: high while a candidate change is being qualified.
- `press_cnt` out `CNT_W`: number of accepted rises, saturating.

## Operation
- Synchroniser: two flops, `s1 <= btn_raw` and `s2 <= s1`. Only `s2` feeds the FSM.
- FSM states: `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`. There is an internal qualification counter `q` of 8 bits and a registered debounced level `stable`.
  - `IDLE_LO`: if `s2`=1, go to `WAIT_HI` and set `q`=1.
  - `WAIT_HI`:
    - If `s2`=0, return to `IDLE_LO` (glitch rejected) with `q`=0 and no pulse.
    - Otherwise, if `q`==`DEBOUNCE_CYCLES`, go to `IDLE_HI`, set `stable`=1 and `rise`=1.
    - Otherwise increment `q`.
  - `IDLE_HI` and `WAIT_LO` mirror the two states above with polarity inverted; acceptance sets `stable`=0 and `fall`=1.
- `busy` = state is `WAIT_HI` or `WAIT_LO`. It is registered with the state.
- `rise` and `fall` are registered and high for exactly one cycle. They are never high together.
- `press_cnt`:
  - Increments on `rise`.
  - Holds at 2^`CNT_W`-1 once reached.
  - `clr_cnt`=1 sets it to 0 on that edge. If `clr_cnt` and a rise acceptance happen on the same edge, clear wins and that rise is not counted.
- `a_out`: see Configuration.

## Timing
- Reset: on any edge with `res`=0, the following all go to 0 and state goes to `IDLE_LO`: `s1`, `s2`, `q`, `stable`, `a_out`, `rise`, `fall`, `busy`, `press_cnt`.
- Reset mid-qualification discards the candidate; no pulse is issued.
- Latency: `btn_raw` steady from before edge k gives `stable`/`rise` visible after edge k+2+`DEBOUNCE_CYCLES`, with `rise` deasserted one cycle later. `DEBOUNCE_CYCLES`=4 gives 6 cycles.
- A glitch of fewer than `DEBOUNCE_CYCLES`+1 synchronised samples never changes `stable`.
- If `btn_raw` is high when reset releases, the block behaves as an ordinary rise: `rise` pulses after `DEBOUNCE_CYCLES`+2 cycles and `press_cnt` becomes 1.
- `clr_cnt` has 1-cycle latency and is independent of the FSM.

## Configuration
- Macro `A_TOGGLE_EN`.
- Defined: `a_out` is a toggle register. It flips on each `rise` edge (same edge `rise` is set), ignores `fall`, and resets to 0. A press-release-press sequence turns the state machine's mode on and off.
- Not defined: `a_out` equals `stable` (level mode); no toggle register exists.
- `rise`, `fall`, `busy` and `press_cnt` behave identically in both builds.

## Test plan
- Reset then clean press, `DEBOUNCE_CYCLES`=4, `btn_raw`=1 before edge 0 → `busy`=1 after edge 2; `rise`=1 and `stable`=1 after edge 6; `rise`=0 after edge 7; `press_cnt`=1.
- Bounce: `btn_raw` pulses high for 3 cycles, 2 low, 2 high, then low → `stable` stays 0, no `rise`, `press_cnt`=0, `busy` returns to 0.
- Release after accepted press → `fall` one cycle at release+6 cycles. In level build `a_out`=0; with `A_TOGGLE_EN`, `a_out` stays 1 until the next accepted press, which drives it to 0.
- `CNT_W`=2: 5 clean presses → `press_cnt` sequence 1, 2, 3, 3, 3. `clr_cnt` on the same edge as the 5th rise → `press_cnt`=0.
- `res`=0 asserted while in `WAIT_HI` → all outputs 0 on that edge, then re-qualification from `IDLE_LO` after release. `btn_raw` held high through reset → `rise` at `DEBOUNCE_CYCLES`+2 cycles after release.
